// File: rtl/match_controller.sv
// Match sequencing for a two-player ball game: serve handshake, scoring,
// inter-point pause and game-over handling.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// SERVE | serve position/velocity presented, waiting for serve_ready
// PLAY  | ball in play, score events accepted
// PAUSE | counting frame ticks before the next serve
// OVER  | a player reached WIN_SCORE, waiting for start
module match_controller #(
    parameter int unsigned        WIN_SCORE    = 11,
    parameter int unsigned        PAUSE_FRAMES = 60,
    parameter logic signed [7:0]  SERVE_VX     = 8'sd2,
    parameter logic signed [7:0]  SERVE_VY     = 8'sd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [31:0] dimensions,
    input  logic [1:0]  playerDidScore,
    input  logic        serve_ready,
    output logic        serve_valid,
    output logic [31:0] serve_position,
    output logic [15:0] serve_velocity,
    output logic [7:0]  score_left,
    output logic [7:0]  score_right,
    output logic        game_active,
    output logic [1:0]  winner,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [7:0] WIN_Q   = 8'(WIN_SCORE);
    localparam logic [7:0] PAUSE_Q = 8'(PAUSE_FRAMES);

    state_t      state_q, state_d;
    logic [7:0]  score_left_q, score_left_d;
    logic [7:0]  score_right_q, score_right_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  pause_cnt_q, pause_cnt_d;
    logic [31:0] serve_pos_q, serve_pos_d;
    logic [15:0] serve_vel_q, serve_vel_d;
    logic        serve_valid_q, serve_valid_d;
    logic        game_active_q, game_active_d;
    logic        vx_neg_q, vx_neg_d;
    logic        vy_neg_q, vy_neg_d;

    logic [15:0]       half_x, half_y;
    logic signed [7:0] vx_val, vy_val;
    logic              transfer;

    assign half_x   = dimensions[31:16] >> 1;
    assign half_y   = dimensions[15:0] >> 1;
    assign transfer = serve_valid_q & serve_ready;

    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_d      = winner_q;
        pause_cnt_d   = pause_cnt_q;
        serve_pos_d   = serve_pos_q;
        serve_vel_d   = serve_vel_q;
        vx_neg_d      = vx_neg_q;
        vy_neg_d      = vy_neg_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = SERVE;
                    score_left_d  = 8'd0;
                    score_right_d = 8'd0;
                    winner_d      = 2'b00;
                    vx_neg_d      = 1'b0;
                    vy_neg_d      = 1'b0;
                end
            end
            SERVE: begin
                if (transfer) begin
                    state_d  = PLAY;
                    vy_neg_d = ~vy_neg_q;
                end
            end
            PLAY: begin
                case (playerDidScore)
                    2'b10: begin
                        // next serve heads toward the player who conceded
                        vx_neg_d = 1'b1;
                        if (score_right_q != WIN_Q) begin
                            score_right_d = score_right_q + 8'd1;
                        end
                        if (score_right_d == WIN_Q) begin
                            state_d  = OVER;
                            winner_d = 2'b10;
                        end else begin
                            state_d     = PAUSE;
                            pause_cnt_d = PAUSE_Q;
                        end
                    end
                    2'b01: begin
                        vx_neg_d = 1'b0;
                        if (score_left_q != WIN_Q) begin
                            score_left_d = score_left_q + 8'd1;
                        end
                        if (score_left_d == WIN_Q) begin
                            state_d  = OVER;
                            winner_d = 2'b01;
                        end else begin
                            state_d     = PAUSE;
                            pause_cnt_d = PAUSE_Q;
                        end
                    end
                    2'b11: begin
                        state_d     = PAUSE;
                        pause_cnt_d = PAUSE_Q;
                    end
                    default: ;
                endcase
            end
            PAUSE: begin
                if (frame_tick) begin
                    if (pause_cnt_q <= 8'd1) begin
                        state_d     = SERVE;
                        pause_cnt_d = 8'd0;
                    end else begin
                        pause_cnt_d = pause_cnt_q - 8'd1;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    state_d       = SERVE;
                    score_left_d  = 8'd0;
                    score_right_d = 8'd0;
                    winner_d      = 2'b00;
                    vx_neg_d      = 1'b0;
                    vy_neg_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // serve fields are captured once on SERVE entry and frozen until transfer
        vx_val = vx_neg_d ? -SERVE_VX : SERVE_VX;
        vy_val = vy_neg_d ? -SERVE_VY : SERVE_VY;
        if (state_d == SERVE && state_q != SERVE) begin
            serve_pos_d = {half_x, half_y};
            serve_vel_d = {vx_val, vy_val};
        end

        serve_valid_d = (state_d == SERVE);
        game_active_d = (state_d == PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            score_left_q  <= 8'd0;
            score_right_q <= 8'd0;
            winner_q      <= 2'b00;
            pause_cnt_q   <= 8'd0;
            serve_pos_q   <= 32'd0;
            serve_vel_q   <= 16'd0;
            serve_valid_q <= 1'b0;
            game_active_q <= 1'b0;
            vx_neg_q      <= 1'b0;
            vy_neg_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            winner_q      <= winner_d;
            pause_cnt_q   <= pause_cnt_d;
            serve_pos_q   <= serve_pos_d;
            serve_vel_q   <= serve_vel_d;
            serve_valid_q <= serve_valid_d;
            game_active_q <= game_active_d;
            vx_neg_q      <= vx_neg_d;
            vy_neg_q      <= vy_neg_d;
        end
    end

    assign serve_valid    = serve_valid_q;
    assign serve_position = serve_pos_q;
    assign serve_velocity = serve_vel_q;
    assign score_left     = score_left_q;
    assign score_right    = score_right_q;
    assign game_active    = game_active_q;
    assign winner         = winner_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: one default instance and one with a
// short match (WIN_SCORE=3, PAUSE_FRAMES=4).
module tb_match_controller;

    logic        clk = 1'b0;
    logic        rst, start, frame_tick, serve_ready;
    logic [31:0] dimensions;
    logic [1:0]  psd;
    logic        serve_valid, game_active;
    logic [31:0] serve_position;
    logic [15:0] serve_velocity;
    logic [7:0]  score_left, score_right;
    logic [1:0]  winner;
    logic [2:0]  state_out;

    logic        w_rst, w_start, w_ready;
    logic [1:0]  w_psd;
    logic        w_valid, w_active;
    logic [31:0] w_pos;
    logic [15:0] w_vel;
    logic [7:0]  w_left, w_right;
    logic [1:0]  w_winner;
    logic [2:0]  w_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    match_controller dut (
        .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
        .dimensions(dimensions), .playerDidScore(psd), .serve_ready(serve_ready),
        .serve_valid(serve_valid), .serve_position(serve_position),
        .serve_velocity(serve_velocity), .score_left(score_left),
        .score_right(score_right), .game_active(game_active), .winner(winner),
        .state_out(state_out)
    );

    match_controller #(.WIN_SCORE(3), .PAUSE_FRAMES(4)) dut_w3 (
        .clk(clk), .rst(w_rst), .start(w_start), .frame_tick(frame_tick),
        .dimensions(dimensions), .playerDidScore(w_psd), .serve_ready(w_ready),
        .serve_valid(w_valid), .serve_position(w_pos),
        .serve_velocity(w_vel), .score_left(w_left),
        .score_right(w_right), .game_active(w_active), .winner(w_winner),
        .state_out(w_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; tick();
            frame_tick = 1'b0; tick();
        end
    endtask

    task automatic transfer();
        serve_ready = 1'b1; tick(); serve_ready = 1'b0;
    endtask

    task automatic w_transfer();
        w_ready = 1'b1; tick(); w_ready = 1'b0;
    endtask

    task automatic w_point(input logic [1:0] side);
        w_psd = side; tick(); w_psd = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; w_rst = 1'b1; tick(); tick();
        rst = 1'b0; w_rst = 1'b0;
        total_cnt++; if (state_out !== 3'd0) $display("FAIL reset_state: got %0d exp 0", state_out); else pass_cnt++;
        total_cnt++; if ({serve_valid, game_active, winner} !== 4'b0) $display("FAIL reset_flags: got %b exp 0000", {serve_valid, game_active, winner}); else pass_cnt++;
        total_cnt++; if ({serve_position, serve_velocity, score_left, score_right} !== 64'd0) $display("FAIL reset_data: got %h exp 0", {serve_position, serve_velocity, score_left, score_right}); else pass_cnt++;
        psd = 2'b10; frame_tick = 1'b1; tick(); psd = 2'b00; frame_tick = 1'b0;
        total_cnt++; if ({state_out, score_right} !== 11'd0) $display("FAIL idle_ignore: got %h exp 0", {state_out, score_right}); else pass_cnt++;
    endtask

    task automatic test_serve();
        dimensions = 32'h0280_01E0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total_cnt++;
            if ({serve_valid, state_out, serve_position, serve_velocity} !== {1'b1, 3'd1, 32'h0140_00F0, 16'h0201})
                $display("FAIL serve_hold[%0d]: got v=%b st=%0d pos=%h vel=%h exp v=1 st=1 pos=014000f0 vel=0201", c, serve_valid, state_out, serve_position, serve_velocity);
            else pass_cnt++;
            if (c < 2) tick();
        end
        transfer();
        total_cnt++; if ({state_out, serve_valid, game_active} !== {3'd2, 1'b0, 1'b1}) $display("FAIL serve_to_play: got st=%0d v=%b a=%b exp st=2 v=0 a=1", state_out, serve_valid, game_active); else pass_cnt++;
    endtask

    task automatic test_point();
        psd = 2'b10; tick(); psd = 2'b00;
        total_cnt++; if ({score_right, score_left, state_out} !== {8'd1, 8'd0, 3'd3}) $display("FAIL point_right: got r=%0d l=%0d st=%0d exp r=1 l=0 st=3", score_right, score_left, state_out); else pass_cnt++;
        psd = 2'b01; start = 1'b1; tick(); psd = 2'b00; start = 1'b0;
        total_cnt++; if ({score_left, state_out} !== {8'd0, 3'd3}) $display("FAIL pause_ignore: got l=%0d st=%0d exp l=0 st=3", score_left, state_out); else pass_cnt++;
        run_frames(59);
        total_cnt++; if (state_out !== 3'd3) $display("FAIL pause_59: got %0d exp 3", state_out); else pass_cnt++;
        run_frames(1);
        total_cnt++; if ({state_out, serve_velocity} !== {3'd1, 16'hFEFF}) $display("FAIL pause_60_serve: got st=%0d vel=%h exp st=1 vel=feff", state_out, serve_velocity); else pass_cnt++;
        transfer();
    endtask

    task automatic test_tie();
        psd = 2'b11; tick(); psd = 2'b00;
        total_cnt++; if ({score_left, score_right, state_out} !== {8'd0, 8'd1, 3'd3}) $display("FAIL tie: got l=%0d r=%0d st=%0d exp l=0 r=1 st=3", score_left, score_right, state_out); else pass_cnt++;
        run_frames(60);
        total_cnt++; if ({state_out, serve_velocity} !== {3'd1, 16'hFE01}) $display("FAIL tie_vx: got st=%0d vel=%h exp st=1 vel=fe01", state_out, serve_velocity); else pass_cnt++;
        start = 1'b1; tick(); start = 1'b0;
        total_cnt++; if ({state_out, serve_velocity, score_right} !== {3'd1, 16'hFE01, 8'd1}) $display("FAIL serve_start_ignore: got st=%0d vel=%h r=%0d exp st=1 vel=fe01 r=1", state_out, serve_velocity, score_right); else pass_cnt++;
        transfer();
    endtask

    task automatic test_reset_mid();
        psd = 2'b01; tick(); psd = 2'b00;
        run_frames(60);
        total_cnt++; if ({state_out, serve_velocity} !== {3'd1, 16'h02FF}) $display("FAIL left_serve_vx: got st=%0d vel=%h exp st=1 vel=02ff", state_out, serve_velocity); else pass_cnt++;
        transfer();
        for (int p = 0; p < 3; p++) begin
            psd = 2'b01; tick(); psd = 2'b00;
            run_frames(60);
            transfer();
        end
        psd = 2'b01; tick(); psd = 2'b00;
        run_frames(40);
        total_cnt++; if ({score_left, state_out} !== {8'd5, 3'd3}) $display("FAIL pre_reset: got l=%0d st=%0d exp l=5 st=3", score_left, state_out); else pass_cnt++;
        rst = 1'b1; frame_tick = 1'b1; tick(); rst = 1'b0; frame_tick = 1'b0;
        total_cnt++;
        if ({state_out, serve_valid, game_active, winner, score_left, score_right, serve_position, serve_velocity} !== 71'd0)
            $display("FAIL reset_mid: got st=%0d l=%0d r=%0d pos=%h vel=%h exp all 0", state_out, score_left, score_right, serve_position, serve_velocity);
        else pass_cnt++;
        start = 1'b1; tick(); start = 1'b0;
        total_cnt++; if ({state_out, serve_velocity} !== {3'd1, 16'h0201}) $display("FAIL reset_restart: got st=%0d vel=%h exp st=1 vel=0201", state_out, serve_velocity); else pass_cnt++;
    endtask

    task automatic test_win();
        dimensions = 32'h0280_01E0;
        w_start = 1'b1; tick(); w_start = 1'b0;
        w_transfer();
        for (int p = 0; p < 2; p++) begin
            w_point(2'b01);
            run_frames(4);
            w_transfer();
        end
        w_point(2'b01);
        total_cnt++; if ({w_left, w_winner, w_state, w_active, w_valid} !== {8'd3, 2'b01, 3'd4, 1'b0, 1'b0}) $display("FAIL win_left: got l=%0d w=%b st=%0d a=%b v=%b exp l=3 w=01 st=4 a=0 v=0", w_left, w_winner, w_state, w_active, w_valid); else pass_cnt++;
        w_point(2'b01); w_point(2'b10); w_point(2'b11);
        total_cnt++; if ({w_left, w_right, w_winner, w_state} !== {8'd3, 8'd0, 2'b01, 3'd4}) $display("FAIL over_ignore: got l=%0d r=%0d w=%b st=%0d exp l=3 r=0 w=01 st=4", w_left, w_right, w_winner, w_state); else pass_cnt++;
        w_start = 1'b1; tick(); w_start = 1'b0;
        total_cnt++; if ({w_left, w_right, w_winner, w_state, w_vel} !== {8'd0, 8'd0, 2'b00, 3'd1, 16'h0201}) $display("FAIL over_restart: got l=%0d r=%0d w=%b st=%0d vel=%h exp 0 0 00 1 0201", w_left, w_right, w_winner, w_state, w_vel); else pass_cnt++;
        w_transfer();
        for (int p = 0; p < 2; p++) begin
            w_point(2'b10);
            run_frames(4);
            w_transfer();
        end
        w_point(2'b10);
        total_cnt++; if ({w_right, w_winner, w_state} !== {8'd3, 2'b10, 3'd4}) $display("FAIL win_right: got r=%0d w=%b st=%0d exp r=3 w=10 st=4", w_right, w_winner, w_state); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic bad;
        w_start = 1'b1; tick(); w_start = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            dimensions = $urandom();
            tick();
            if (w_pos !== 32'h0140_00F0 || w_valid !== 1'b1 || w_vel !== 16'h0201) bad = 1'b1;
        end
        total_cnt++; if (bad !== 1'b0) $display("FAIL backpressure: got pos=%h v=%b vel=%h exp pos=014000f0 v=1 vel=0201", w_pos, w_valid, w_vel); else pass_cnt++;
        w_transfer();
        total_cnt++; if (w_state !== 3'd2) $display("FAIL bp_transfer: got %0d exp 2", w_state); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; frame_tick = 1'b0; serve_ready = 1'b0;
        psd = 2'b00; dimensions = 32'd0;
        w_rst = 1'b0; w_start = 1'b0; w_ready = 1'b0; w_psd = 2'b00;
        test_reset();
        test_serve();
        test_point();
        test_tie();
        test_reset_mid();
        test_win();
        test_backpressure();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
